seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Time-multiplexed scanner for the Anvyl multi-digit seven-segment display.
//  Holds an N-digit hex value and rotates through the digits, driving one anode
//  at a time. Sits directly upstream of seven_segs: its Digit and EnableSegs
//  outputs feed that decoder's Digit and EnableSegs inputs.
//  Inserts a blanking interval at each digit switch to suppress ghosting.
//  New values are committed only at frame boundaries, so a partial update is never shown.
// PARAMETERS
//  N_DIGITS     8      number of digits scanned; must be >= 1
//  TICK_DIV     50000  clocks per digit slot; must be >= 2
//  BLANK_CYC    16     blanking clocks at the start of each slot; 0 <= BLANK_CYC < TICK_DIV
//  AN_ACT_LOW   1      1: anodes are active-low; 0: anodes are active-high
// PORTS
//  Clk         in   1            system clock; everything is on its rising edge
//  Rst_n       in   1            synchronous reset, active-low
//  Value       in   4*N_DIGITS   hex digits; digit i = Value[4i+3:4i]; digit 0 is rightmost
//  DigitMask   in   N_DIGITS     1 = digit i lit; 0 = digit i blank for its whole slot
//  Load        in   1            1-cycle strobe; captures Value and DigitMask into the pending regs
//  LoadPending out  1            1 while a captured value is waiting for the frame boundary
//  FrameDone   out  1            1-cycle pulse in the cycle the slot index wraps N_DIGITS-1 -> 0
//  Digit       out  4            nibble for the active slot; goes to seven_segs.Digit
//  EnableSegs  out  1            segment enable; goes to seven_segs.EnableSegs
//  An          out  N_DIGITS     anode selects, one-hot while showing (polarity set by AN_ACT_LOW)
// BEHAVIOUR
//  State: slot counter cnt (0..TICK_DIV-1) and slot index idx (0..N_DIGITS-1).
//  - Each cycle cnt increments. When cnt = TICK_DIV-1, cnt wraps to 0 and idx advances.
//  - idx wraps from N_DIGITS-1 to 0.
//  Two phases per slot, decoded from cnt:
//  - BLANK (cnt < BLANK_CYC): all anodes inactive, EnableSegs = 0.
//  - SHOW (cnt >= BLANK_CYC): An[idx] active and all other anodes inactive.
//    EnableSegs = act_mask[idx]; Digit = act_val[idx].
//    If act_mask[idx] = 0, the anodes stay inactive as well.
//  - Digit, EnableSegs and An are registered. In cycle t they reflect (cnt, idx) of cycle t-1.
//  - In BLANK, Digit holds its last value.
//  Shadow update:
//  - Load = 1 sets pend_val <= Value, pend_mask <= DigitMask, LoadPending <= 1.
//  - A later Load before the boundary overwrites the pending regs (last write wins).
//  - Boundary = the cycle where cnt = TICK_DIV-1 and idx = N_DIGITS-1. FrameDone pulses in
//    that cycle (registered, visible in the next cycle).
//  - At the boundary, if LoadPending = 1: act_val <= pend_val, act_mask <= pend_mask,
//    LoadPending <= 0.
//  - If Load is asserted in the boundary cycle itself, the live Value/DigitMask commit directly
//    to the act regs and LoadPending ends at 0.
//  Reset (Rst_n = 0 sampled at a rising edge) is honoured in any phase, including mid-slot:
//  - cnt = 0, idx = 0.
//  - act_val = 0, act_mask = 0, pend_val = 0, pend_mask = 0.
//  - LoadPending = 0, FrameDone = 0, Digit = 0, EnableSegs = 0, all An inactive.
//  - Any pending load is discarded.
//  - After reset the display stays dark until the first committed load.
//  - Frame period = N_DIGITS*TICK_DIV cycles exactly; there are no stalls.
// TESTING  (N_DIGITS=4, TICK_DIV=8, BLANK_CYC=2, AN_ACT_LOW=1)
//  1 Rst_n=0 for 5 cycles -> An=4'b1111, EnableSegs=0, Digit=0, LoadPending=0, FrameDone=0.
//  2 Load Value=16'h1234, Mask=4'hF right after reset -> LoadPending=1 until the first
//    FrameDone (32 cycles after reset release). Next frame shows Digit 4/3/2/1 with
//    An 1110/1101/1011/0111, each for 6 cycles after a 2-cycle all-1111 blank.
//  3 Mask=4'b0101 committed -> slots 1 and 3 show An=1111, EnableSegs=0 for all 8 cycles;
//    slots 0 and 2 are normal.
//  4 Load h1111 then h2222 in the same frame -> only h2222 appears after the boundary.
//    Load h3333 exactly on the boundary cycle -> h3333 is shown in the following frame and
//    LoadPending stays 0.
//  5 Rst_n=0 during SHOW of slot 2 with a load pending -> one cycle later all reset values
//    hold and LoadPending=0.
//  6 Free-run 10 frames -> FrameDone spacing is exactly 32 cycles; blank width is exactly
//    2 cycles per slot.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: rotates through N hex digits one anode at a time,
// blanks the first BLANK_CYC clocks of each slot, and commits new values only at frame wrap.
module seg_scan_mux #(
    parameter int N_DIGITS   = 8,
    parameter int TICK_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int AN_ACT_LOW = 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [4*N_DIGITS-1:0]   Value,
    input  logic [N_DIGITS-1:0]     DigitMask,
    input  logic                    Load,
    output logic                    LoadPending,
    output logic                    FrameDone,
    output logic [3:0]              Digit,
    output logic                    EnableSegs,
    output logic [N_DIGITS-1:0]     An
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]    BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{(AN_ACT_LOW != 0)}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] act_val, pend_val;
    logic [N_DIGITS-1:0]   act_mask, pend_mask;

    logic                  cnt_last_p0, boundary_p0, show_p0, lit_p0;
    logic [3:0]            nib_p0;

    // One-hot anode pattern for the selected slot, folded into the board polarity.
    function automatic logic [N_DIGITS-1:0] an_drive(input logic [IDX_W-1:0] sel);
        logic [N_DIGITS-1:0] hot;
        for (int i = 0; i < N_DIGITS; i++) begin
            hot[i] = (sel == IDX_W'(i));
        end
        return hot ^ AN_OFF;
    endfunction

    // Stage p0: slot decode from the current counter state
    assign cnt_last_p0 = (cnt == CNT_LAST);
    assign boundary_p0 = cnt_last_p0 && (idx == IDX_LAST);
    assign show_p0     = (cnt >= BLANK_END);
    assign lit_p0      = show_p0 && act_mask[idx];
    assign nib_p0      = act_val[{idx, 2'b00} +: 4];

    // Stage p1: registered scan state, shadow commit and display outputs
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            act_val     <= '0;
            act_mask    <= '0;
            pend_val    <= '0;
            pend_mask   <= '0;
            LoadPending <= 1'b0;
            FrameDone   <= 1'b0;
            Digit       <= '0;
            EnableSegs  <= 1'b0;
            An          <= AN_OFF;
        end else begin
            cnt       <= cnt_last_p0 ? '0 : cnt + CNT_W'(1);
            if (cnt_last_p0) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            FrameDone <= boundary_p0;

            // A load landing on the boundary itself bypasses the shadow regs.
            if (boundary_p0) begin
                if (Load) begin
                    act_val  <= Value;
                    act_mask <= DigitMask;
                end else if (LoadPending) begin
                    act_val  <= pend_val;
                    act_mask <= pend_mask;
                end
                LoadPending <= 1'b0;
            end else if (Load) begin
                pend_val    <= Value;
                pend_mask   <= DigitMask;
                LoadPending <= 1'b1;
            end

            EnableSegs <= lit_p0;
            An         <= lit_p0 ? an_drive(idx) : AN_OFF;
            if (show_p0) begin
                Digit <= nib_p0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a 4-digit, 8-clock-slot, 2-clock-blank configuration.
module tb_seg_scan_mux;

    logic        Clk;
    logic        Rst_n;
    logic [15:0] Value;
    logic [3:0]  DigitMask;
    logic        Load;
    logic        LoadPending;
    logic        FrameDone;
    logic [3:0]  Digit;
    logic        EnableSegs;
    logic [3:0]  An;

    seg_scan_mux #(
        .N_DIGITS  (4),
        .TICK_DIV  (8),
        .BLANK_CYC (2),
        .AN_ACT_LOW(1)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Value      (Value),
        .DigitMask  (DigitMask),
        .Load       (Load),
        .LoadPending(LoadPending),
        .FrameDone  (FrameDone),
        .Digit      (Digit),
        .EnableSegs (EnableSegs),
        .An         (An)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  mask;
        logic [3:0]  digit;
        logic [3:0]  an;
        logic        en;
    } vec_t;

    vec_t tbl [20];

    int   errors = 0;
    int   checks = 0;
    int   cur_g  = -1;
    int   cur_o  = -1;
    logic lp_exp = 1'b0;
    logic [3:0] prev_digit = 4'h0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s group=%0d off=%0d actual=%0h required=%0h", name, cur_g, cur_o, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_an", An, 4'hF);
        chk("rst_en", EnableSegs, 1'b0);
        chk("rst_digit", Digit, 4'h0);
        chk("rst_lp", LoadPending, 1'b0);
        chk("rst_fd", FrameDone, 1'b0);
    endtask

    // One full frame (32 clocks) checked against table group g; optional loads at offsets 0, 20, 31.
    task automatic run_frame(input int g,
                             input bit l1, input logic [15:0] v1, input logic [3:0] m1,
                             input bit l2, input logic [15:0] v2, input logic [3:0] m2,
                             input bit lb, input logic [15:0] vb, input logic [3:0] mb);
        vec_t r;
        bit   ld;
        int   s;
        int   c;
        cur_g = g;
        for (int o = 0; o < 32; o++) begin
            s  = o / 8;
            c  = o % 8;
            ld = 1'b0;
            if (o == 0 && l1) begin
                ld = 1'b1; Value = v1; DigitMask = m1;
            end else if (o == 20 && l2) begin
                ld = 1'b1; Value = v2; DigitMask = m2;
            end else if (o == 31 && lb) begin
                ld = 1'b1; Value = vb; DigitMask = mb;
            end
            Load = ld;
            step();
            Load  = 1'b0;
            cur_o = o;
            if (o == 31) lp_exp = 1'b0;
            else if (ld) lp_exp = 1'b1;
            r = tbl[4*g + s];
            if (c < 2) begin
                chk("blank_an", An, 4'hF);
                chk("blank_en", EnableSegs, 1'b0);
                chk("blank_digit", Digit, prev_digit);
            end else begin
                chk("show_an", An, r.an);
                chk("show_en", EnableSegs, r.en);
                chk("show_digit", Digit, r.digit);
                prev_digit = r.digit;
            end
            chk("framedone", FrameDone, (o == 31));
            chk("loadpending", LoadPending, lp_exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog group=%0d off=%0d actual=timeout required=finish", cur_g, cur_o);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // group 0: dark display
        for (int s = 0; s < 4; s++) tbl[s] = '{16'h0000, 4'h0, 4'h0, 4'hF, 1'b0};
        // group 1: h1234, all lit
        tbl[4]  = '{16'h1234, 4'hF, 4'h4, 4'b1110, 1'b1};
        tbl[5]  = '{16'h1234, 4'hF, 4'h3, 4'b1101, 1'b1};
        tbl[6]  = '{16'h1234, 4'hF, 4'h2, 4'b1011, 1'b1};
        tbl[7]  = '{16'h1234, 4'hF, 4'h1, 4'b0111, 1'b1};
        // group 2: hABCD with mask 0101
        tbl[8]  = '{16'hABCD, 4'b0101, 4'hD, 4'b1110, 1'b1};
        tbl[9]  = '{16'hABCD, 4'b0101, 4'hC, 4'b1111, 1'b0};
        tbl[10] = '{16'hABCD, 4'b0101, 4'hB, 4'b1011, 1'b1};
        tbl[11] = '{16'hABCD, 4'b0101, 4'hA, 4'b1111, 1'b0};
        // group 3: h2222, group 4: h3333
        tbl[12] = '{16'h2222, 4'hF, 4'h2, 4'b1110, 1'b1};
        tbl[13] = '{16'h2222, 4'hF, 4'h2, 4'b1101, 1'b1};
        tbl[14] = '{16'h2222, 4'hF, 4'h2, 4'b1011, 1'b1};
        tbl[15] = '{16'h2222, 4'hF, 4'h2, 4'b0111, 1'b1};
        tbl[16] = '{16'h3333, 4'hF, 4'h3, 4'b1110, 1'b1};
        tbl[17] = '{16'h3333, 4'hF, 4'h3, 4'b1101, 1'b1};
        tbl[18] = '{16'h3333, 4'hF, 4'h3, 4'b1011, 1'b1};
        tbl[19] = '{16'h3333, 4'hF, 4'h3, 4'b0111, 1'b1};

        Rst_n = 1'b0; Load = 1'b0; Value = 16'h0; DigitMask = 4'h0;
        repeat (5) step();
        chk_reset();

        Rst_n = 1'b1;
        run_frame(0, 1, tbl[4].val, tbl[4].mask, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
        run_frame(1, 1, tbl[8].val, tbl[8].mask, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
        run_frame(2, 1, 16'h1111, 4'hF, 1, tbl[12].val, tbl[12].mask, 0, 16'h0, 4'h0);
        run_frame(3, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1, tbl[16].val, tbl[16].mask);
        run_frame(4, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

        // Reset in the SHOW phase of slot 2 while h5555 is pending.
        cur_g = -1;
        Load = 1'b1; Value = 16'h5555; DigitMask = 4'hF;
        step();
        Load = 1'b0;
        repeat (19) step();
        cur_o = 19;
        chk("pre_rst_lp", LoadPending, 1'b1);
        chk("pre_rst_an", An, 4'b1011);
        chk("pre_rst_digit", Digit, 4'h3);
        chk("pre_rst_en", EnableSegs, 1'b1);
        Rst_n = 1'b0;
        step();
        chk_reset();
        Rst_n = 1'b1;
        lp_exp = 1'b0;
        prev_digit = 4'h0;
        run_frame(0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
        run_frame(0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

        // Ten back-to-back frames: frame spacing and blank width every slot.
        run_frame(0, 1, tbl[4].val, tbl[4].mask, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
        repeat (9) run_frame(1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
